// File: rtl/seq_det_sched.sv
// seq_det_sched: shares one serial sequence detector between two requesters and returns
// per-word match counts. Define STRICT_PRIO_EN for fixed priority to requester 0 (default: round-robin).
module seq_det_sched #(
    parameter int WIDTH   = 8,
    parameter int DET_LAT = 1,
    localparam int CNT_W  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    output logic [1:0]       req_ready,
    output logic             det_rst,
    output logic             det_x,
    input  logic             det_y,
    output logic             res_valid,
    output logic             res_id,
    output logic [CNT_W-1:0] res_count,
    output logic             busy
);

    localparam int CYC_W = $clog2(WIDTH + DET_LAT + 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(WIDTH + DET_LAT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_r;
    logic             rr_last_r;
    logic             owner_r;
    logic [WIDTH-1:0] shreg_r;
    logic [CNT_W-1:0] count_r;
    logic [CYC_W-1:0] cyc_r;

    logic [1:0]       grant_s;
    logic             accept_s;
    logic             lat_ok_s;
    logic [CNT_W-1:0] count_next_s;

    // Arbitration among valid requesters; ties go away from the last winner.
    always_comb begin
        grant_s = 2'b00;
        if (req_valid == 2'b11) begin
`ifdef STRICT_PRIO_EN
            grant_s = 2'b01;
`else
            grant_s = rr_last_r ? 2'b01 : 2'b10;
`endif
        end else begin
            grant_s = req_valid;
        end
    end

    // Ready only while idle; a handshake is any granted valid.
    always_comb begin
        req_ready = 2'b00;
        if (state_r == IDLE) begin
            req_ready = grant_s;
        end else begin
            req_ready = 2'b00;
        end
        accept_s = |(req_valid & req_ready);
    end

    // Early RUN cycles see detector responses to bits shifted before the clear.
    generate
        if (DET_LAT == 0) begin : g_mealy
            assign lat_ok_s = 1'b1;
        end else begin : g_lat
            assign lat_ok_s = (cyc_r >= CYC_W'(DET_LAT));
        end
    endgenerate

    assign count_next_s = count_r + CNT_W'(lat_ok_s & det_y);
    assign busy         = (state_r != IDLE);

    // Scheduler FSM with registered detector drive and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            det_rst   <= 1'b1;
            det_x     <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_count <= {CNT_W{1'b0}};
            rr_last_r <= 1'b1;
            owner_r   <= 1'b0;
            shreg_r   <= {WIDTH{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            cyc_r     <= {CYC_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    det_x     <= 1'b0;
                    res_valid <= 1'b0;
                    if (accept_s) begin
                        shreg_r   <= grant_s[1] ? req_data1 : req_data0;
                        owner_r   <= grant_s[1];
                        rr_last_r <= grant_s[1];
                        det_rst   <= 1'b1;
                        state_r   <= CLEAR;
                    end else begin
                        det_rst   <= 1'b0;
                    end
                end
                CLEAR: begin
                    det_rst <= 1'b0;
                    det_x   <= shreg_r[WIDTH-1];
                    shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
                    count_r <= {CNT_W{1'b0}};
                    cyc_r   <= {CYC_W{1'b0}};
                    state_r <= RUN;
                end
                RUN: begin
                    shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
                    count_r <= count_next_s;
                    cyc_r   <= cyc_r + CYC_W'(1);
                    if (cyc_r == CYC_LAST) begin
                        det_x     <= 1'b0;
                        res_valid <= 1'b1;
                        res_id    <= owner_r;
                        res_count <= count_next_s;
                        state_r   <= DONE;
                    end else begin
                        det_x     <= shreg_r[WIDTH-1];
                    end
                end
                DONE: begin
                    res_valid <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    det_rst   <= 1'b0;
                    det_x     <= 1'b0;
                    res_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_sched.sv
// Scoreboard bench for seq_det_sched driving a registered overlapping "101" detector.
// Expected results are computed from the word bits and the arbitration rule.
module tb_seq_det_sched;

    localparam int W = 8;
    localparam int L = 1;

    typedef struct {
        int id;
        int cnt;
        int cyc;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [1:0]   req_valid;
    logic [W-1:0] req_data0;
    logic [W-1:0] req_data1;
    logic [1:0]   req_ready;
    logic         det_rst;
    logic         det_x;
    logic         det_y;
    logic         res_valid;
    logic         res_id;
    logic [3:0]   res_count;
    logic         busy;

    seq_det_sched #(.WIDTH(W), .DET_LAT(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_ready (req_ready),
        .det_rst   (det_rst),
        .det_x     (det_x),
        .det_y     (det_y),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_count (res_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Detector under shared use: registered, overlapping "101", cleared by det_rst.
    logic [1:0] dh;
    logic       dy;
    always @(posedge clk) begin
        if (det_rst) begin
            dh <= 2'b00;
            dy <= 1'b0;
        end else begin
            dh <= {dh[0], det_x};
            dy <= (dh == 2'b10) && det_x;
        end
    end
    assign det_y = dy;

    int           cycle;
    int           checks;
    int           errors;
    bit           chk_en;
    int           free_cycle;
    int           last_acc;
    logic [W-1:0] last_word;
    bit           rr_m;
    exp_t         q[$];

    int           g;
    int           rel;
    logic [1:0]   exp_ready;
    bit           exp_res;

    initial begin
        cycle = 0;
        forever begin
            @(posedge clk);
            cycle = cycle + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic int count101(input logic [W-1:0] w);
        int n;
        n = 0;
        for (int i = W - 1; i >= 2; i--) begin
            if (w[i] && !w[i-1] && w[i-2]) n++;
        end
        return n;
    endfunction

    // Winner id for a valid pattern, -1 if none; rr is the previous winner.
    function automatic int pick(input logic [1:0] v, input bit rr);
        if (v == 2'b00) return -1;
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
`ifdef STRICT_PRIO_EN
        return 0;
`else
        return rr ? 0 : 1;
`endif
    endfunction

    // Monitor: per-cycle expectations and scoreboard pops on res_valid.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                g = (cycle >= free_cycle) ? pick(req_valid, rr_m) : -1;
                exp_ready = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
                check("req_ready", 32'(req_ready), 32'(exp_ready));
                rel = cycle - last_acc;
                check("det_rst", 32'(det_rst), 32'(rel == 1));
                check("det_x", 32'(det_x), (rel >= 2 && rel < 2 + W) ? 32'(last_word[W+1-rel]) : 32'd0);
                check("busy", 32'(busy), 32'(rel >= 1 && rel <= 2 + W + L));
                exp_res = (q.size() > 0) && (q[0].cyc == cycle);
                check("res_valid", 32'(res_valid), 32'(exp_res));
                if (exp_res) begin
                    check("res_id", 32'(res_id), 32'(q[0].id));
                    check("res_count", 32'(res_count), 32'(q[0].cnt));
                    void'(q.pop_front());
                end
                if (g >= 0) begin
                    last_word  = (g == 0) ? req_data0 : req_data1;
                    last_acc   = cycle;
                    free_cycle = cycle + W + L + 3;
                    rr_m       = (g == 1);
                    q.push_back('{id: g, cnt: count101(last_word), cyc: cycle + W + L + 2});
                end
            end
        end
    end

    task automatic send(input int id, input logic [W-1:0] d, output int acc);
        int n;
        if (id == 0) req_data0 = d;
        else req_data1 = d;
        req_valid[id] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[id] && n < 40);
        acc = cycle;
        check("accept", 32'(req_ready[id]), 32'd1);
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
    endtask

    task automatic expect_result(input int id, input int cnt, input int acc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 30);
        check("dir_valid", 32'(res_valid), 32'd1);
        check("dir_latency", 32'(cycle - acc), 32'd11);
        check("dir_id", 32'(res_id), 32'(id));
        check("dir_count", 32'(res_count), 32'(cnt));
    endtask

    task automatic wait_grant(output int who);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == 2'b00 && n < 40);
        check("grant_seen", 32'(req_ready != 2'b00), 32'd1);
        who = req_ready[1] ? 1 : 0;
    endtask

    initial begin
        int acc;
        int who;
        int n;
        checks     = 0;
        errors     = 0;
        chk_en     = 1'b0;
        rr_m       = 1'b1;
        last_acc   = -100;
        free_cycle = 0;
        last_word  = '0;
        rst        = 1'b1;
        req_valid  = 2'b00;
        req_data0  = '0;
        req_data1  = '0;

        #12 rst = 1'b0;
        #1;
        check("rst_det_rst", 32'(det_rst), 32'd1);
        check("rst_det_x", 32'(det_x), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        check("rst_res_count", 32'(res_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 chk_en = 1'b1;

        // Both requesters held valid: alternating grants from reset.
        req_data0 = W'($urandom);
        req_data1 = W'($urandom);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_grant(who);
`ifdef STRICT_PRIO_EN
            check("grant_order", 32'(who), 32'd0);
`else
            check("grant_order", 32'(who), 32'(k % 2));
`endif
            @(posedge clk);
            #1;
            if (who == 1) req_data1 = W'($urandom);
            else req_data0 = W'($urandom);
        end
        req_valid = 2'b00;

        send(0, 8'hAA, acc);
        expect_result(0, 3, acc);
        send(1, 8'hB6, acc);
        expect_result(1, 2, acc);
        send(0, 8'h00, acc);
        expect_result(0, 0, acc);
        send(0, 8'hFF, acc);
        expect_result(0, 0, acc);

        // Abort mid-RUN; arbitration must restart with requester 0 winning a tie.
        send(0, 8'h5A, acc);
        repeat (5) @(posedge clk);
        #1 chk_en = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_det_rst", 32'(det_rst), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_res_valid", 32'(res_valid), 32'd0);
        q.delete();
        rr_m       = 1'b1;
        last_acc   = -100;
        free_cycle = 0;
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        req_data0 = 8'hAA;
        req_data1 = W'($urandom);
        req_valid = 2'b11;
        wait_grant(who);
        acc = cycle;
        check("rr_after_rst", 32'(who), 32'd0);
        @(posedge clk);
        #1 req_valid = 2'b00;
        expect_result(0, 3, acc);

        // Random valid patterns with random hold times, including early withdrawal.
        for (int it = 0; it < 60; it++) begin
            req_valid = 2'($urandom_range(0, 3));
            req_data0 = W'($urandom);
            req_data1 = W'($urandom);
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1;
        end
        req_valid = 2'b00;

        n = 0;
        while (q.size() > 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        check("drain", 32'(q.size()), 32'd0);
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
